// File: rtl/sdram_ppfifo_pkg.sv
// Shared constants for the SDRAM read ping-pong FIFO: buffer states, depth and count width.
package sdram_ppfifo_pkg;

    localparam int COUNT_W        = 24;
    localparam int BUF_ADDR_WIDTH = 9;
    localparam int BUF_DEPTH      = 1 << BUF_ADDR_WIDTH;

    localparam logic [1:0] BUF_EMPTY   = 2'd0;
    localparam logic [1:0] BUF_FILLING = 2'd1;
    localparam logic [1:0] BUF_FULL    = 2'd2;
    localparam logic [1:0] BUF_READING = 2'd3;

    function automatic int buf_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/ppfifo_buffer_ram.sv
// Simple dual-port buffer RAM: one write port, one read port with a registered output.
// A read returns data 1 cycle after i_rd_en; the output holds while i_rd_en is low.
module ppfifo_buffer_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/sdram_read_ppfifo.sv
// Ping-pong FIFO between the SDRAM read controller and a block-transfer consumer.
// Claim -> read_count in 1 cycle, word 0 in 2 cycles; reader paces via read_strobe, writer via write_ready.
module sdram_read_ppfifo
    import sdram_ppfifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic [1:0]            o_write_ready,
    input  logic [1:0]            i_write_activate,
    output logic [COUNT_W-1:0]    o_write_size,
    input  logic                  i_write_strobe,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    output logic                  o_starved,
    output logic                  o_read_ready,
    input  logic                  i_read_activate,
    output logic [COUNT_W-1:0]    o_read_count,
    input  logic                  i_read_strobe,
    output logic [DATA_WIDTH-1:0] o_read_data
);

    localparam int                  DEPTH     = buf_depth(ADDR_WIDTH);
    localparam int                  CNT_BITS  = ADDR_WIDTH + 1;
    localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);

    logic [1:0][1:0]            r_state, w_state_nxt;
    logic [1:0][CNT_BITS-1:0]   r_wcount, w_wcount_nxt;
    logic [1:0]                 w_full_nxt, w_reading_nxt, w_empty_nxt, w_new_full;
    logic [1:0][DATA_WIDTH-1:0] w_ram_q;

    logic [1:0]          r_write_ready;
    logic                r_next_read, w_next_read_nxt;
    logic                r_claimed, r_rsel, r_data_vld, r_rd_act_prev;
    logic                r_read_ready, r_starved;
    logic [CNT_BITS-1:0] r_rptr;
    logic [COUNT_W-1:0]  r_read_count;

    logic w_act_ok, w_wsel, w_wr_en;
    logic w_claim, w_release, w_prefetch, w_rd_strobe, w_fetch;

    // Both activate bits high is a writer protocol error: neither is honoured.
    assign w_act_ok = (i_write_activate != 2'b11);
    assign w_wsel   = i_write_activate[1];
    assign w_wr_en  = i_write_strobe && w_act_ok && (i_write_activate != 2'b00)
                      && (r_state[w_wsel] == BUF_FILLING)
                      && (r_wcount[w_wsel] != DEPTH_CNT);

    assign w_claim     = i_read_activate && !r_rd_act_prev && r_read_ready;
    assign w_release   = r_claimed && !i_read_activate;
    assign w_prefetch  = r_claimed && !r_data_vld && !w_release;
    assign w_rd_strobe = r_data_vld && i_read_strobe && !w_release
                         && (COUNT_W'(r_rptr) < r_read_count);
    assign w_fetch     = w_prefetch || w_rd_strobe;

    always_comb begin
        w_state_nxt     = r_state;
        w_wcount_nxt    = r_wcount;
        w_full_nxt      = '0;
        w_reading_nxt   = '0;
        w_empty_nxt     = '0;
        w_new_full      = '0;
        w_next_read_nxt = r_next_read;

        for (int i = 0; i < 2; i++) begin
            case (r_state[i])
                BUF_EMPTY: begin
                    if (i_write_activate[i] && w_act_ok) begin
                        w_state_nxt[i]  = BUF_FILLING;
                        w_wcount_nxt[i] = '0;
                    end
                end
                BUF_FILLING: begin
                    if (!i_write_activate[i]) begin
                        w_state_nxt[i] = (r_wcount[i] != '0) ? BUF_FULL : BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (w_claim && (r_next_read == 1'(i))) begin
                        w_state_nxt[i] = BUF_READING;
                    end
                end
                default: begin
                    if (w_release && (r_rsel == 1'(i))) begin
                        w_state_nxt[i] = BUF_EMPTY;
                    end
                end
            endcase
        end

        if (w_wr_en) begin
            w_wcount_nxt[w_wsel] = r_wcount[w_wsel] + CNT_BITS'(1);
        end

        for (int i = 0; i < 2; i++) begin
            w_full_nxt[i]    = (w_state_nxt[i] == BUF_FULL);
            w_reading_nxt[i] = (w_state_nxt[i] == BUF_READING);
            w_empty_nxt[i]   = (w_state_nxt[i] == BUF_EMPTY);
            w_new_full[i]    = (r_state[i] == BUF_FILLING) && w_full_nxt[i];
        end

        // Oldest-full tracking; a buffer joining an already-full peer stays second.
        if (w_claim) begin
            w_next_read_nxt = !r_next_read;
        end
        if (w_new_full[1] && !w_full_nxt[0]) begin
            w_next_read_nxt = 1'b1;
        end
        if (w_new_full[0] && (!w_full_nxt[1] || w_new_full[1])) begin
            w_next_read_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= '0;
            r_wcount      <= '0;
            r_next_read   <= 1'b0;
            r_write_ready <= 2'b00;
            r_read_ready  <= 1'b0;
            r_starved     <= 1'b0;
            r_rd_act_prev <= 1'b0;
            r_claimed     <= 1'b0;
            r_rsel        <= 1'b0;
            r_data_vld    <= 1'b0;
            r_rptr        <= '0;
            r_read_count  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wcount      <= w_wcount_nxt;
            r_next_read   <= w_next_read_nxt;
            r_write_ready <= w_empty_nxt & ~i_write_activate;
            r_read_ready  <= (|w_full_nxt) && !(|w_reading_nxt);
            r_starved     <= !(|w_full_nxt) && !i_read_activate;
            r_rd_act_prev <= i_read_activate;

            if (w_claim) begin
                r_claimed    <= 1'b1;
                r_rsel       <= r_next_read;
                r_read_count <= COUNT_W'(r_wcount[r_next_read]);
                r_rptr       <= '0;
                r_data_vld   <= 1'b0;
            end else if (w_release) begin
                r_claimed    <= 1'b0;
                r_read_count <= '0;
                r_rptr       <= '0;
                r_data_vld   <= 1'b0;
            end else if (w_fetch) begin
                // r_rptr is the next address to fetch, one ahead of o_read_data.
                r_rptr     <= r_rptr + CNT_BITS'(1);
                r_data_vld <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_buf
        ppfifo_buffer_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_ram (
            .i_clk    (i_clk),
            .i_wr_en  (w_wr_en && (w_wsel == 1'(g))),
            .i_wr_addr(r_wcount[w_wsel][ADDR_WIDTH-1:0]),
            .i_wr_data(i_write_data),
            .i_rd_en  (w_fetch),
            .i_rd_addr(r_rptr[ADDR_WIDTH-1:0]),
            .o_rd_data(w_ram_q[g])
        );
    end

    assign o_write_ready = r_write_ready;
    assign o_write_size  = COUNT_W'(DEPTH);
    assign o_starved     = r_starved;
    assign o_read_ready  = r_read_ready;
    assign o_read_count  = r_read_count;
    assign o_read_data   = r_data_vld ? w_ram_q[r_rsel] : '0;

endmodule

// File: tb/tb_sdram_read_ppfifo.sv
// Self-checking bench for sdram_read_ppfifo: vector table for the basic transfer,
// scripted sequences with a data scoreboard for ordering, saturation, protocol and reset cases.
module tb_sdram_read_ppfifo;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wr_rdy;
    logic [1:0]    wa;
    logic [23:0]   wsize;
    logic          ws;
    logic [DW-1:0] wd;
    logic          starved;
    logic          rr;
    logic          ra;
    logic [23:0]   rc;
    logic          rs;
    logic [DW-1:0] rd;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb[$];
    int          cnt_q[$];
    logic [31:0] last_rd;

    typedef struct {
        logic [1:0]  wa;
        logic        ws;
        logic [31:0] wd;
        logic        ra;
        logic        rs;
        logic [1:0]  e_wr;
        logic        e_rr;
        logic        e_st;
        logic [23:0] e_rc;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    sdram_read_ppfifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .o_write_ready   (wr_rdy),
        .i_write_activate(wa),
        .o_write_size    (wsize),
        .i_write_strobe  (ws),
        .i_write_data    (wd),
        .o_starved       (starved),
        .o_read_ready    (rr),
        .i_read_activate (ra),
        .o_read_count    (rc),
        .i_read_strobe   (rs),
        .o_read_data     (rd)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fill_buf(input int b, input int n, input logic [31:0] base);
        wa = (b == 0) ? 2'b01 : 2'b10;
        tick();
        for (int k = 0; k < n; k++) begin
            ws = 1'b1;
            wd = base + 32'(k);
            if (k < DEPTH) sb.push_back(wd);
            tick();
        end
        ws = 1'b0;
        wa = 2'b00;
        tick();
        if (n > 0) cnt_q.push_back((n > DEPTH) ? DEPTH : n);
    endtask

    task automatic drain(input string nm);
        int          cnt;
        logic [31:0] e;
        for (int t = 0; t < 50 && !rr; t++) tick();
        check({nm, "_rdy"}, 64'(rr), 64'd1);
        cnt = (cnt_q.size() > 0) ? cnt_q.pop_front() : 0;
        ra = 1'b1;
        tick();
        check({nm, "_cnt"}, 64'(rc), 64'(cnt));
        tick();
        for (int k = 0; k < cnt; k++) begin
            e = (sb.size() > 0) ? sb.pop_front() : 32'hFFFF_FFFF;
            check({nm, "_dat"}, 64'(rd), 64'(e));
            last_rd = rd;
            if (k < cnt - 1) begin
                rs = 1'b1;
                tick();
                rs = 1'b0;
            end
        end
        ra = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'b01, 1'b0, 32'h0,    1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 24'd0, 32'h0};
        vecs[1]  = '{2'b01, 1'b1, 32'h1000, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 24'd0, 32'h0};
        vecs[2]  = '{2'b01, 1'b1, 32'h1001, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 24'd0, 32'h0};
        vecs[3]  = '{2'b01, 1'b1, 32'h1002, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 24'd0, 32'h0};
        vecs[4]  = '{2'b01, 1'b1, 32'h1003, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 24'd0, 32'h0};
        vecs[5]  = '{2'b00, 1'b0, 32'h0,    1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 24'd0, 32'h0};
        vecs[6]  = '{2'b00, 1'b0, 32'h0,    1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 24'd4, 32'h0};
        vecs[7]  = '{2'b00, 1'b0, 32'h0,    1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 24'd4, 32'h1000};
        vecs[8]  = '{2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 24'd4, 32'h1001};
        vecs[9]  = '{2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 24'd4, 32'h1002};
        vecs[10] = '{2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 24'd4, 32'h1003};
        vecs[11] = '{2'b00, 1'b0, 32'h0,    1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 24'd4, 32'h1003};
        vecs[12] = '{2'b00, 1'b0, 32'h0,    1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 24'd0, 32'h0};

        rst = 1'b1; wa = 2'b00; ws = 1'b0; wd = '0; ra = 1'b0; rs = 1'b0;
        tick();
        tick();
        check("rst_wr_rdy",  64'(wr_rdy),  64'd0);
        check("rst_starved", 64'(starved), 64'd0);
        check("rst_rd_rdy",  64'(rr),      64'd0);
        check("rst_rd_cnt",  64'(rc),      64'd0);
        check("rst_rd_dat",  64'(rd),      64'd0);

        rst = 1'b0;
        tick(); tick(); tick();
        check("idle_wr_rdy",  64'(wr_rdy),  64'd3);
        check("idle_starved", 64'(starved), 64'd1);
        check("idle_rd_rdy",  64'(rr),      64'd0);
        check("idle_wsize",   64'(wsize),   64'd512);

        // Basic transfer of four words, one vector per clock.
        for (int i = 0; i < 13; i++) begin
            wa = vecs[i].wa; ws = vecs[i].ws; wd = vecs[i].wd;
            ra = vecs[i].ra; rs = vecs[i].rs;
            tick();
            check($sformatf("vec%0d_wr_rdy", i),  64'(wr_rdy),  64'(vecs[i].e_wr));
            check($sformatf("vec%0d_rd_rdy", i),  64'(rr),      64'(vecs[i].e_rr));
            check($sformatf("vec%0d_starved", i), 64'(starved), 64'(vecs[i].e_st));
            check($sformatf("vec%0d_rd_cnt", i),  64'(rc),      64'(vecs[i].e_rc));
            check($sformatf("vec%0d_rd_dat", i),  64'(rd),      64'(vecs[i].e_rd));
        end
        wa = 2'b00; ws = 1'b0; ra = 1'b0; rs = 1'b0;

        // Two full buffers: buffer 0 completed first must be read first.
        fill_buf(0, 2, 32'h1100);
        fill_buf(1, 3, 32'h1200);
        check("order_starved", 64'(starved), 64'd0);
        drain("order0");
        drain("order1");
        check("order_wr_rdy", 64'(wr_rdy), 64'd3);

        // Overfill: count saturates at the buffer depth.
        fill_buf(0, 520, 32'h2000);
        drain("sat");
        check("sat_last_word", 64'(last_rd), 64'h21FF);

        // Activate and release with no writes.
        wa = 2'b01;
        tick();
        check("zero_wr_rdy_act", 64'(wr_rdy), 64'd2);
        wa = 2'b00;
        tick();
        check("zero_wr_rdy_rel", 64'(wr_rdy), 64'd3);
        check("zero_rd_rdy",     64'(rr),     64'd0);
        tick();
        check("zero_rd_rdy_late", 64'(rr), 64'd0);

        // Both activate bits set: nothing is claimed or written.
        wa = 2'b11; ws = 1'b1; wd = 32'hDEAD;
        tick();
        check("both_act_wr_rdy", 64'(wr_rdy), 64'd0);
        wa = 2'b00; ws = 1'b0;
        tick();
        check("both_rel_wr_rdy", 64'(wr_rdy),  64'd3);
        check("both_rel_rd_rdy", 64'(rr),      64'd0);
        check("both_rel_starved", 64'(starved), 64'd1);

        // read_activate raised before data is ready must not claim.
        ra = 1'b1;
        tick();
        check("early_starved", 64'(starved), 64'd0);
        fill_buf(0, 1, 32'h4000);
        tick();
        check("early_rd_rdy", 64'(rr), 64'd1);
        check("early_rd_cnt", 64'(rc), 64'd0);
        ra = 1'b0;
        tick();
        drain("early");

        // Reset in the middle of a read with the writer holding buffer 1.
        fill_buf(0, 4, 32'h3000);
        ra = 1'b1;
        tick();
        tick();
        check("mid_dat0", 64'(rd), 64'h3000);
        rs = 1'b1;
        tick();
        check("mid_dat1", 64'(rd), 64'h3001);
        rs = 1'b0;
        wa = 2'b10;
        tick();
        check("mid_wr_rdy", 64'(wr_rdy), 64'd0);
        rst = 1'b1;
        tick();
        check("mrst_wr_rdy",  64'(wr_rdy),  64'd0);
        check("mrst_starved", 64'(starved), 64'd0);
        check("mrst_rd_rdy",  64'(rr),      64'd0);
        check("mrst_rd_cnt",  64'(rc),      64'd0);
        check("mrst_rd_dat",  64'(rd),      64'd0);
        rst = 1'b0; ra = 1'b0; wa = 2'b00;
        tick();
        check("post_wr_rdy",  64'(wr_rdy),  64'd3);
        check("post_starved", 64'(starved), 64'd1);
        check("post_rd_rdy",  64'(rr),      64'd0);
        sb.delete();
        cnt_q.delete();
        fill_buf(1, 2, 32'h5000);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
